// File: rtl/mem_frame_writer.sv
// rtl/mem_frame_writer.sv - per-port ring writer with descriptor FIFO; optional counters under `MEM_WR_STATS_EN
module mem_frame_writer #(
    parameter int pPORTS      = 4,
    parameter int pREGION_AW  = 8,
    parameter int pDESC_DEPTH = 8,
    localparam int PW = (pPORTS > 1) ? $clog2(pPORTS) : 1,
    localparam int AW = pREGION_AW,
    localparam int DW = (pDESC_DEPTH > 1) ? $clog2(pDESC_DEPTH) : 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_en_mem,
    input  logic [31:0]       i_data,
    input  logic [PW-1:0]     i_port_num,
    input  logic [1:0]        i_info_port,
    input  logic [1:0]        i_extra_byte,
    output logic              o_mem_we,
    output logic [PW+AW-1:0]  o_mem_addr,
    output logic [31:0]       o_mem_data,
    output logic              o_desc_valid,
    input  logic              i_desc_ready,
    output logic [PW-1:0]     o_desc_port,
    output logic [AW-1:0]     o_desc_addr,
    output logic [AW:0]       o_desc_len,
    output logic [1:0]        o_desc_extra,
    input  logic              i_rel_valid,
    input  logic [PW-1:0]     i_rel_port,
    input  logic [AW:0]       i_rel_len,
    output logic [15:0]       o_drop_cnt,
    output logic [15:0]       o_frame_cnt
);

    localparam logic [1:0] INFO_MID = 2'b00;
    localparam logic [1:0] INFO_SOF = 2'b01;
    localparam logic [1:0] INFO_EOF = 2'b10;
    localparam logic [1:0] INFO_ONE = 2'b11;

    localparam logic [AW:0] RD_L    = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] LEN_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [DW:0] DEPTH_L = (DW+1)'(pDESC_DEPTH);
    localparam int          DESC_W  = PW + 2*AW + 3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_IN_FRAME = 2'd1,
        ST_DISCARD  = 2'd2
    } ctx_state_t;

    // per-port ring contexts
    ctx_state_t  state_q  [pPORTS];
    logic [AW-1:0] wr_ptr_q [pPORTS];
    logic [AW-1:0] start_q  [pPORTS];
    logic [AW:0]   len_q    [pPORTS];
    logic [AW:0]   used_q   [pPORTS];
    logic [AW:0]   used_d   [pPORTS];

    // descriptor FIFO
    logic [DESC_W-1:0] fifo_q [pDESC_DEPTH];
    logic [DW-1:0]     rd_q, wr_q;
    logic [DW:0]       cnt_q;
    logic [DESC_W-1:0] head;

    // next-state of the context addressed by the incoming word
    logic [PW-1:0]     wp;
    ctx_state_t        st_cur, st_d;
    logic [AW-1:0]     ptr_cur, ptr_d, start_d, wr_addr, push_start;
    logic [AW:0]       len_d, word_dec, push_len;
    logic              word_inc, we_d, push, pop, can_push, full;
    logic [1:0]        drop_n;
    logic [DESC_W-1:0] push_desc;

    assign pop      = (cnt_q != '0) && i_desc_ready;
    assign can_push = (cnt_q != DEPTH_L) || pop;

    // decide what the incoming word does to its port context
    always_comb begin
        wp         = i_port_num;
        st_cur     = state_q[wp];
        ptr_cur    = wr_ptr_q[wp];
        st_d       = st_cur;
        ptr_d      = ptr_cur;
        start_d    = start_q[wp];
        len_d      = len_q[wp];
        wr_addr    = ptr_cur;
        word_inc   = 1'b0;
        word_dec   = '0;
        we_d       = 1'b0;
        push       = 1'b0;
        push_start = start_q[wp];
        push_len   = LEN_ONE;
        drop_n     = 2'd0;
        full       = (used_q[wp] == RD_L);
        if (i_en_mem) begin
            case (st_cur)
                ST_IN_FRAME: begin
                    case (i_info_port)
                        INFO_MID: begin
                            if (full) begin
                                ptr_d    = start_q[wp];
                                word_dec = len_q[wp];
                                len_d    = '0;
                                drop_n   = 2'd1;
                                st_d     = ST_DISCARD;
                            end else begin
                                we_d     = 1'b1;
                                ptr_d    = ptr_cur + 1'b1;
                                len_d    = len_q[wp] + 1'b1;
                                word_inc = 1'b1;
                            end
                        end
                        INFO_EOF: begin
                            st_d  = ST_IDLE;
                            len_d = '0;
                            if (full || !can_push) begin
                                ptr_d    = start_q[wp];
                                word_dec = len_q[wp];
                                drop_n   = 2'd1;
                            end else begin
                                we_d     = 1'b1;
                                ptr_d    = ptr_cur + 1'b1;
                                word_inc = 1'b1;
                                push     = 1'b1;
                                push_len = len_q[wp] + 1'b1;
                            end
                        end
                        INFO_SOF: begin
                            // abandon the open frame and restart a new one at its start
                            word_dec = len_q[wp];
                            drop_n   = 2'd1;
                            we_d     = 1'b1;
                            wr_addr  = start_q[wp];
                            ptr_d    = start_q[wp] + 1'b1;
                            len_d    = LEN_ONE;
                            word_inc = 1'b1;
                        end
                        default: begin
                            // single-word frame aborts the open one, then commits alone
                            word_dec = len_q[wp];
                            len_d    = '0;
                            ptr_d    = start_q[wp];
                            st_d     = ST_IDLE;
                            if (can_push) begin
                                drop_n   = 2'd1;
                                we_d     = 1'b1;
                                wr_addr  = start_q[wp];
                                ptr_d    = start_q[wp] + 1'b1;
                                word_inc = 1'b1;
                                push     = 1'b1;
                            end else begin
                                drop_n   = 2'd2;
                            end
                        end
                    endcase
                end
                default: begin
                    case (i_info_port)
                        INFO_SOF: begin
                            if (full) begin
                                drop_n = 2'd1;
                                st_d   = ST_DISCARD;
                            end else begin
                                start_d  = ptr_cur;
                                we_d     = 1'b1;
                                ptr_d    = ptr_cur + 1'b1;
                                len_d    = LEN_ONE;
                                word_inc = 1'b1;
                                st_d     = ST_IN_FRAME;
                            end
                        end
                        INFO_ONE: begin
                            st_d = ST_IDLE;
                            if (st_cur == ST_IDLE) begin
                                if (full || !can_push) begin
                                    drop_n = 2'd1;
                                end else begin
                                    start_d    = ptr_cur;
                                    we_d       = 1'b1;
                                    ptr_d      = ptr_cur + 1'b1;
                                    word_inc   = 1'b1;
                                    push       = 1'b1;
                                    push_start = ptr_cur;
                                end
                            end
                        end
                        INFO_EOF: begin
                            if (st_cur == ST_DISCARD) st_d = ST_IDLE;
                            else                      drop_n = 2'd1;
                        end
                        default: begin
                            if (st_cur == ST_IDLE) drop_n = 2'd1;
                        end
                    endcase
                end
            endcase
        end
        push_desc = {wp, push_start, push_len, i_extra_byte};
    end

    // occupancy: word write, rewind and release net into one clamped update
    always_comb begin : used_calc
        logic [AW+1:0] add_v;
        logic [AW+1:0] sub_v;
        for (int p = 0; p < pPORTS; p++) begin
            add_v = {1'b0, used_q[p]};
            sub_v = '0;
            if (wp == PW'(p)) begin
                add_v = add_v + {{(AW+1){1'b0}}, word_inc};
                sub_v = {1'b0, word_dec};
            end
            if (i_rel_valid && (i_rel_port == PW'(p))) begin
                sub_v = sub_v + {1'b0, i_rel_len};
            end
            used_d[p] = (add_v > sub_v) ? (AW+1)'(add_v - sub_v) : '0;
        end
    end

    // context state machine and registered RAM write port
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int p = 0; p < pPORTS; p++) begin
                state_q[p]  <= ST_IDLE;
                wr_ptr_q[p] <= '0;
                start_q[p]  <= '0;
                len_q[p]    <= '0;
                used_q[p]   <= '0;
            end
            o_mem_we   <= 1'b0;
            o_mem_addr <= '0;
            o_mem_data <= '0;
        end else begin
            for (int p = 0; p < pPORTS; p++) begin
                used_q[p] <= used_d[p];
            end
            if (i_en_mem) begin
                state_q[wp]  <= st_d;
                wr_ptr_q[wp] <= ptr_d;
                start_q[wp]  <= start_d;
                len_q[wp]    <= len_d;
            end
            o_mem_we <= we_d;
            if (we_d) begin
                o_mem_addr <= {wp, wr_addr};
                o_mem_data <= i_data;
            end
        end
    end

    // descriptor FIFO; simultaneous push and pop both proceed even when full
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_q] <= push_desc;
                wr_q         <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
            cnt_q <= cnt_q + (DW+1)'(push) - (DW+1)'(pop);
        end
    end

    assign head         = fifo_q[rd_q];
    assign o_desc_valid = (cnt_q != '0);
    assign o_desc_port  = o_desc_valid ? head[DESC_W-1 -: PW]   : '0;
    assign o_desc_addr  = o_desc_valid ? head[2*AW+2 -: AW]     : '0;
    assign o_desc_len   = o_desc_valid ? head[AW+2 -: AW+1]     : '0;
    assign o_desc_extra = o_desc_valid ? head[1:0]              : '0;

`ifdef MEM_WR_STATS_EN
    logic [15:0] drop_cnt_q, frame_cnt_q;
    logic [16:0] drop_sum;

    assign drop_sum = {1'b0, drop_cnt_q} + {15'd0, drop_n};

    // saturating drop and commit counters
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            drop_cnt_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            if (push && (frame_cnt_q != 16'hFFFF)) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end

    assign o_drop_cnt  = drop_cnt_q;
    assign o_frame_cnt = frame_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = ^drop_n;
    assign o_drop_cnt   = '0;
    assign o_frame_cnt  = '0;
`endif

endmodule

// File: tb/tb_mem_frame_writer.sv
// tb/tb_mem_frame_writer.sv - self-checking bench for mem_frame_writer
`timescale 1ns/1ps
module tb_mem_frame_writer;
    localparam int PORTS = 4;
    localparam int RD    = 256;
    localparam int DEPTH = 8;
    localparam logic [1:0] I_MID = 2'b00, I_SOF = 2'b01, I_EOF = 2'b10, I_ONE = 2'b11;

    logic        clk;
    logic        reset, en, desc_ready, rel_valid;
    logic [31:0] data;
    logic [1:0]  port, info, extra, rel_port;
    logic [8:0]  rel_len;
    logic        mem_we, desc_valid;
    logic [9:0]  mem_addr;
    logic [31:0] mem_data;
    logic [1:0]  desc_port, desc_extra;
    logic [7:0]  desc_addr;
    logic [8:0]  desc_len;
    logic [15:0] drop_cnt, frame_cnt;

    int checks   = 0;
    int failures = 0;

    mem_frame_writer dut (
        .i_clk(clk), .i_reset(reset), .i_en_mem(en), .i_data(data),
        .i_port_num(port), .i_info_port(info), .i_extra_byte(extra),
        .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_data(mem_data),
        .o_desc_valid(desc_valid), .i_desc_ready(desc_ready),
        .o_desc_port(desc_port), .o_desc_addr(desc_addr), .o_desc_len(desc_len),
        .o_desc_extra(desc_extra), .i_rel_valid(rel_valid), .i_rel_port(rel_port),
        .i_rel_len(rel_len), .o_drop_cnt(drop_cnt), .o_frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: per-port ring bookkeeping and a descriptor queue
    typedef struct { int port; int addr; int len; int extra; } desc_t;
    desc_t m_q[$];
    int    pend [PORTS][$];
    int    m_ptr [PORTS], m_used [PORTS], m_start [PORTS], m_len [PORTS], m_delta [PORTS];
    bit    m_open [PORTS], m_disc [PORTS];
    int    m_drop, m_frame;
    bit    e_we;
    int    e_addr;
    logic [31:0] e_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < PORTS; i++) begin
            m_ptr[i] = 0; m_used[i] = 0; m_start[i] = 0; m_len[i] = 0;
            m_open[i] = 0; m_disc[i] = 0;
            pend[i].delete();
        end
        m_q.delete();
        m_drop = 0; m_frame = 0; e_we = 0;
    endfunction

    function automatic void m_abort(int p);
        m_ptr[p] = m_start[p];
        m_delta[p] -= m_len[p];
        m_len[p] = 0;
        m_open[p] = 0;
        m_drop++;
    endfunction

    function automatic void m_write(int p, logic [31:0] d);
        e_we = 1; e_addr = p * RD + m_ptr[p]; e_data = d;
        m_ptr[p] = (m_ptr[p] + 1) % RD;
        m_delta[p] += 1;
    endfunction

    function automatic void m_commit(int p, int st, int ln, int x);
        desc_t d;
        d.port = p; d.addr = st; d.len = ln; d.extra = x;
        m_q.push_back(d);
        m_frame++;
    endfunction

    function automatic void model_step();
        desc_t d;
        bit pop, can_push, full;
        int p;
        if (reset) begin
            m_reset();
            return;
        end
        foreach (m_delta[i]) m_delta[i] = 0;
        e_we = 0;
        pop = desc_ready && (m_q.size() > 0);
        can_push = (m_q.size() < DEPTH) || pop;
        if (pop) begin
            d = m_q.pop_front();
            pend[d.port].push_back(d.len);
        end
        if (en) begin
            p = int'(port);
            full = (m_used[p] == RD);
            case (info)
                I_SOF: begin
                    if (m_open[p]) begin m_abort(p); full = 0; end
                    if (full) begin m_drop++; m_disc[p] = 1; end
                    else begin
                        m_start[p] = m_ptr[p]; m_write(p, data);
                        m_len[p] = 1; m_open[p] = 1; m_disc[p] = 0;
                    end
                end
                I_MID: begin
                    if (m_open[p]) begin
                        if (full) begin m_abort(p); m_disc[p] = 1; end
                        else begin m_write(p, data); m_len[p]++; end
                    end else if (!m_disc[p]) m_drop++;
                end
                I_EOF: begin
                    if (m_open[p]) begin
                        if (full || !can_push) m_abort(p);
                        else begin
                            m_commit(p, m_start[p], m_len[p] + 1, int'(extra));
                            m_write(p, data);
                            m_open[p] = 0;
                        end
                    end else if (m_disc[p]) m_disc[p] = 0;
                    else m_drop++;
                end
                default: begin
                    if (m_disc[p] && !m_open[p]) m_disc[p] = 0;
                    else begin
                        if (m_open[p]) begin m_abort(p); full = 0; end
                        if (full || !can_push) m_drop++;
                        else begin
                            m_commit(p, m_ptr[p], 1, int'(extra));
                            m_write(p, data);
                        end
                    end
                end
            endcase
        end
        if (rel_valid) m_delta[rel_port] -= int'(rel_len);
        for (int i = 0; i < PORTS; i++) begin
            m_used[i] = m_used[i] + m_delta[i];
            if (m_used[i] < 0) m_used[i] = 0;
        end
    endfunction

    // one clock: update the model, then compare DUT outputs a little after the edge
    task automatic cycle();
        int exp_drop, exp_frame;
        model_step();
        @(posedge clk);
        #1;
`ifdef MEM_WR_STATS_EN
        exp_drop  = (m_drop  > 65535) ? 65535 : m_drop;
        exp_frame = (m_frame > 65535) ? 65535 : m_frame;
`else
        exp_drop  = 0;
        exp_frame = 0;
`endif
        check("mem_we", mem_we, e_we);
        if (e_we) begin
            check("mem_addr", mem_addr, e_addr);
            check("mem_data", mem_data, e_data);
        end
        check("desc_valid", desc_valid, m_q.size() > 0);
        if (m_q.size() > 0) begin
            check("desc_port",  desc_port,  m_q[0].port);
            check("desc_addr",  desc_addr,  m_q[0].addr);
            check("desc_len",   desc_len,   m_q[0].len);
            check("desc_extra", desc_extra, m_q[0].extra);
        end
        check("drop_cnt",  drop_cnt,  exp_drop);
        check("frame_cnt", frame_cnt, exp_frame);
    endtask

    task automatic word(input int p, input logic [1:0] inf, input logic [31:0] d, input logic [1:0] x);
        en = 1'b1; port = 2'(p); info = inf; data = d; extra = x;
        cycle();
        en = 1'b0;
    endtask

    task automatic release_port(input int p);
        check("pending_release", pend[p].size() > 0, 1);
        if (pend[p].size() > 0) begin
            rel_valid = 1'b1; rel_port = 2'(p); rel_len = 9'(pend[p].pop_front());
            cycle();
            rel_valid = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},   mem_we, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_data"}, mem_data, 0);
        check({tag, "_dv"},   desc_valid, 0);
        check({tag, "_dfld"}, {desc_port, desc_addr, desc_len, desc_extra}, 0);
        check({tag, "_cnt"},  {drop_cnt, frame_cnt}, 0);
    endtask

    typedef struct {
        logic en; logic [1:0] port; logic [1:0] info; logic [1:0] extra; logic [31:0] data; logic ready;
        logic exp_we; logic [9:0] exp_addr; logic exp_valid; logic [8:0] exp_len;
        logic [7:0] exp_daddr; logic [1:0] exp_dport; logic [1:0] exp_dextra;
    } vec_t;
    vec_t tbl [10];

    initial begin
        int r, rp;
        tbl[0] = '{1'b1, 2'd1, I_SOF, 2'd0, 32'hA0, 1'b0, 1'b1, 10'h100, 1'b0, 9'd0, 8'd0, 2'd0, 2'd0};
        tbl[1] = '{1'b1, 2'd1, I_MID, 2'd0, 32'hA1, 1'b0, 1'b1, 10'h101, 1'b0, 9'd0, 8'd0, 2'd0, 2'd0};
        tbl[2] = '{1'b1, 2'd1, I_MID, 2'd0, 32'hA2, 1'b0, 1'b1, 10'h102, 1'b0, 9'd0, 8'd0, 2'd0, 2'd0};
        tbl[3] = '{1'b1, 2'd1, I_EOF, 2'd2, 32'hA3, 1'b0, 1'b1, 10'h103, 1'b1, 9'd4, 8'd0, 2'd1, 2'd2};
        tbl[4] = '{1'b0, 2'd0, I_MID, 2'd0, 32'h00, 1'b1, 1'b0, 10'h000, 1'b0, 9'd0, 8'd0, 2'd0, 2'd0};
        tbl[5] = '{1'b1, 2'd0, I_SOF, 2'd0, 32'hB0, 1'b0, 1'b1, 10'h000, 1'b0, 9'd0, 8'd0, 2'd0, 2'd0};
        tbl[6] = '{1'b1, 2'd0, I_MID, 2'd0, 32'hB1, 1'b0, 1'b1, 10'h001, 1'b0, 9'd0, 8'd0, 2'd0, 2'd0};
        tbl[7] = '{1'b1, 2'd0, I_SOF, 2'd0, 32'hB2, 1'b0, 1'b1, 10'h000, 1'b0, 9'd0, 8'd0, 2'd0, 2'd0};
        tbl[8] = '{1'b1, 2'd0, I_EOF, 2'd1, 32'hB3, 1'b0, 1'b1, 10'h001, 1'b1, 9'd2, 8'd0, 2'd0, 2'd1};
        tbl[9] = '{1'b0, 2'd0, I_MID, 2'd0, 32'h00, 1'b1, 1'b0, 10'h000, 1'b0, 9'd0, 8'd0, 2'd0, 2'd0};

        reset = 1'b1; en = 1'b0; data = '0; port = '0; info = '0; extra = '0;
        desc_ready = 1'b0; rel_valid = 1'b0; rel_port = '0; rel_len = '0;
        m_reset();
        cycle();
        cycle();
        check_all_zero("reset");
        reset = 1'b0;

        // single frame and abort/restart, table driven
        for (int i = 0; i < 10; i++) begin
            en = tbl[i].en; port = tbl[i].port; info = tbl[i].info; extra = tbl[i].extra;
            data = tbl[i].data; desc_ready = tbl[i].ready;
            cycle();
            check("tbl_we", mem_we, tbl[i].exp_we);
            if (tbl[i].exp_we) begin
                check("tbl_addr", mem_addr, tbl[i].exp_addr);
                check("tbl_data", mem_data, tbl[i].data);
            end
            check("tbl_valid", desc_valid, tbl[i].exp_valid);
            if (tbl[i].exp_valid) begin
                check("tbl_desc", {desc_port, desc_addr, desc_len, desc_extra},
                      {tbl[i].exp_dport, tbl[i].exp_daddr, tbl[i].exp_len, tbl[i].exp_dextra});
            end
        end
        en = 1'b0; desc_ready = 1'b0;
`ifdef MEM_WR_STATS_EN
        check("abort_drop", drop_cnt, 1);
`endif

        // interleaved frames on ports 0 and 2
        word(0, I_SOF, 32'hC0, 2'd0);
        word(2, I_SOF, 32'hD0, 2'd0);
        word(0, I_MID, 32'hC1, 2'd0);
        word(2, I_MID, 32'hD1, 2'd0);
        word(0, I_EOF, 32'hC2, 2'd3);
        check("ilv_p0_addr", mem_addr, 10'h004);
        word(2, I_EOF, 32'hD2, 2'd0);
        check("ilv_p2_addr", mem_addr, 10'h202);
        check("ilv_head0", {desc_port, desc_addr, desc_len, desc_extra}, {2'd0, 8'd2, 9'd3, 2'd3});
        desc_ready = 1'b1;
        cycle();
        check("ilv_head1", {desc_port, desc_addr, desc_len, desc_extra}, {2'd2, 8'd0, 9'd3, 2'd0});
        cycle();
        check("ilv_empty", desc_valid, 0);
        desc_ready = 1'b0;

        // fill port 3 completely, overflow drop, release and wrap
        word(3, I_SOF, $urandom, 2'd0);
        for (int i = 0; i < 254; i++) word(3, I_MID, $urandom, 2'd0);
        word(3, I_EOF, $urandom, 2'd1);
        check("full_addr", mem_addr, 10'h3FF);
        check("full_desc", {desc_addr, desc_len}, {8'd0, 9'd256});
        desc_ready = 1'b1;
        cycle();
        desc_ready = 1'b0;
        word(3, I_SOF, 32'hE0, 2'd0);
        check("ovf_sof_we", mem_we, 0);
        word(3, I_EOF, 32'hE1, 2'd0);
        check("ovf_eof_we", mem_we, 0);
        check("ovf_no_desc", desc_valid, 0);
        release_port(3);
        word(3, I_SOF, 32'hE2, 2'd0);
        check("wrap_addr", mem_addr, 10'h300);
        word(3, I_EOF, 32'hE3, 2'd2);
        check("wrap_desc", {desc_port, desc_addr, desc_len}, {2'd3, 8'd0, 9'd2});
        desc_ready = 1'b1;
        cycle();
        desc_ready = 1'b0;

        // descriptor FIFO overflow on port 2 (write pointer at 3)
        for (int k = 0; k < DEPTH + 1; k++) begin
            word(2, I_ONE, 32'h100 + k, 2'(k));
            if (k < DEPTH) check("fifo_we", {mem_we, mem_addr}, {1'b1, 10'(10'h203 + k)});
            else           check("fifo_full_we", mem_we, 0);
            check("fifo_valid", desc_valid, 1);
        end
        desc_ready = 1'b1;
        word(2, I_ONE, 32'h1FF, 2'd3);
        check("full_pushpop_we", {mem_we, mem_addr}, {1'b1, 10'h20B});
        for (int k = 0; k < DEPTH; k++) begin
            check("fifo_order", {desc_addr, desc_len}, {8'(4 + k), 9'd1});
            cycle();
        end
        check("fifo_drained", desc_valid, 0);
        desc_ready = 1'b0;

        // reset in the middle of a frame
        word(1, I_SOF, 32'hF0, 2'd0);
        word(1, I_MID, 32'hF1, 2'd0);
        reset = 1'b1; en = 1'b1; port = 2'd1; info = I_MID; data = 32'hF2;
        cycle();
        check_all_zero("midrst");
        reset = 1'b0; en = 1'b0;
        word(1, I_SOF, 32'hF3, 2'd0);
        check("post_rst_addr", mem_addr, 10'h100);
        word(1, I_EOF, 32'hF4, 2'd1);
        check("post_rst_desc", {desc_port, desc_addr, desc_len, desc_extra}, {2'd1, 8'd0, 9'd2, 2'd1});

        // randomized traffic with in-order releases of consumed frames
        for (int i = 0; i < 800; i++) begin
            en = (($urandom % 5) != 0);
            port = 2'($urandom % 4);
            r = $urandom % 10;
            info = (r < 5) ? I_MID : (r < 7) ? I_SOF : (r < 9) ? I_EOF : I_ONE;
            data = $urandom;
            extra = 2'($urandom % 4);
            desc_ready = (($urandom % 10) < 7);
            rel_valid = 1'b0;
            if (($urandom % 3) == 0) begin
                rp = $urandom % 4;
                if (pend[rp].size() > 0) begin
                    rel_valid = 1'b1; rel_port = 2'(rp); rel_len = 9'(pend[rp].pop_front());
                end
            end
            cycle();
        end
        en = 1'b0; rel_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
